// File: rtl/clken_monitor.sv
// clken_monitor
//   Watches the CPU clock-enable strobe from the system clock divider. It
//   measures the spacing between successive clken pulses in clk25 cycles,
//   reports every measured interval, declares lock after LOCK_COUNT
//   consecutive in-tolerance intervals, and raises a sticky fault when a
//   locked strobe drifts out of tolerance or stops.
//
// Ports
//   clk25        in   25 MHz master clock (only clock)
//   rst          in   synchronous active-high reset
//   clken        in   monitored enable strobe
//   fault_clr    in   single-cycle request to clear fault
//   period       out  last measured interval, CNT_WIDTH bits
//   period_valid out  one-cycle pulse when period updates
//   locked       out  high while the strobe runs at the expected rate
//   fault        out  sticky loss-of-strobe indication
module clken_monitor #(
  parameter int EXPECTED_PERIOD = 25,
  parameter int TOLERANCE       = 0,
  parameter int LOCK_COUNT      = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk25,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 fault_clr,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 fault
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_WIDTH-1:0] PERIOD_LO = CNT_WIDTH'(EXPECTED_PERIOD - TOLERANCE);
  localparam logic [CNT_WIDTH-1:0] PERIOD_HI = CNT_WIDTH'(EXPECTED_PERIOD + TOLERANCE);
  // cnt value on the cycle of the latest legal pulse slot
  localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(EXPECTED_PERIOD + TOLERANCE - 1);
  localparam logic [GOOD_W-1:0]    GOOD_MAX  = GOOD_W'(LOCK_COUNT);

  if (LOCK_COUNT < 1) begin : g_bad_lock_count
    $error("clken_monitor: LOCK_COUNT must be at least 1");
  end
  if (EXPECTED_PERIOD <= TOLERANCE) begin : g_bad_tolerance
    $error("clken_monitor: EXPECTED_PERIOD must exceed TOLERANCE");
  end
  if (EXPECTED_PERIOD + TOLERANCE > (2 ** CNT_WIDTH) - 1) begin : g_bad_width
    $error("clken_monitor: CNT_WIDTH too small for EXPECTED_PERIOD+TOLERANCE");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nx;
  logic [GOOD_W-1:0]      good, good_nx;
  logic [CNT_WIDTH-1:0]   period_nx;
  logic                   period_valid_nx;
  logic                   fault_nx;
  logic                   fault_event;
  logic [CNT_WIDTH-1:0]   interval;
  logic                   timeout;
  logic                   interval_ok;
  logic [GOOD_W-1:0]      good_inc;

  function automatic logic in_range(input logic [CNT_WIDTH-1:0] iv);
    return (iv >= PERIOD_LO) && (iv <= PERIOD_HI);
  endfunction

  function automatic logic [GOOD_W-1:0] sat_inc(input logic [GOOD_W-1:0] g);
    if (g >= GOOD_MAX)
      return GOOD_MAX;
    else
      return g + GOOD_W'(1);
  endfunction

  // Measurement and next-state decode
  always_comb begin
    state_nx        = state;
    cnt_nx          = clken ? '0 : cnt + CNT_WIDTH'(1);
    good_nx         = good;
    period_nx       = period;
    period_valid_nx = 1'b0;
    fault_event     = 1'b0;

    // In SEARCH/LOCKED cnt never passes LAST_SLOT, so cnt+1 cannot wrap
    // when a measurement is taken.
    interval    = cnt + CNT_WIDTH'(1);
    interval_ok = in_range(interval);
    good_inc    = sat_inc(good);
    timeout     = !clken && (cnt == LAST_SLOT);

    case (state)
      IDLE: begin
        // First pulse only establishes the reference edge.
        if (clken) begin
          state_nx = SEARCH;
          good_nx  = '0;
        end
      end

      SEARCH: begin
        if (clken) begin
          period_nx       = interval;
          period_valid_nx = 1'b1;
          if (interval_ok) begin
            good_nx = good_inc;
            if (good_inc == GOOD_MAX)
              state_nx = LOCKED;
          end else begin
            // Out-of-range pulse simply restarts the count from here.
            good_nx = '0;
          end
        end else if (timeout) begin
          state_nx = IDLE;
          good_nx  = '0;
        end
      end

      LOCKED: begin
        if (clken) begin
          period_nx       = interval;
          period_valid_nx = 1'b1;
          if (!interval_ok) begin
            fault_event = 1'b1;
            good_nx     = '0;
            state_nx    = SEARCH;
          end
        end else if (timeout) begin
          fault_event = 1'b1;
          good_nx     = '0;
          state_nx    = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
        good_nx  = '0;
      end
    endcase

    // A new fault takes priority over a simultaneous clear request.
    if (fault_event)
      fault_nx = 1'b1;
    else if (fault_clr)
      fault_nx = 1'b0;
    else
      fault_nx = fault;
  end

  // Registered state and outputs
  always_ff @(posedge clk25) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      good         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      good         <= good_nx;
      period       <= period_nx;
      period_valid <= period_valid_nx;
      locked       <= (state_nx == LOCKED);
      fault        <= fault_nx;
    end
  end

endmodule

// File: tb/tb_clken_monitor.sv
// tb_clken_monitor
//   Self-checking bench for clken_monitor. Two instances: dut uses the
//   default parameters (25 +/- 0, lock after 4 intervals) and dut_t uses
//   TOLERANCE = 1. Directed table vectors and hand sequences cover the
//   locking, fault, clear-race, reset and timeout cases; a randomized phase
//   compares both instances against a timestamp-based reference model.
module tb_clken_monitor;

  localparam int EP = 25;
  localparam int LC = 4;

  logic       clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  logic       rst, clken, fault_clr;
  logic [7:0] period;
  logic       period_valid, locked, fault;

  logic       rst_t, clken_t, clr_t;
  logic [7:0] period_t;
  logic       period_valid_t, locked_t, fault_t;

  clken_monitor #(
    .EXPECTED_PERIOD(EP), .TOLERANCE(0), .LOCK_COUNT(LC), .CNT_WIDTH(8)
  ) dut (
    .clk25(clk25), .rst(rst), .clken(clken), .fault_clr(fault_clr),
    .period(period), .period_valid(period_valid), .locked(locked), .fault(fault)
  );

  clken_monitor #(
    .EXPECTED_PERIOD(EP), .TOLERANCE(1), .LOCK_COUNT(LC), .CNT_WIDTH(8)
  ) dut_t (
    .clk25(clk25), .rst(rst_t), .clken(clken_t), .fault_clr(clr_t),
    .period(period_t), .period_valid(period_valid_t), .locked(locked_t),
    .fault(fault_t)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int p, input int v, input int l, input int f);
    chk({tag, ".period"}, 32'(period), p);
    chk({tag, ".period_valid"}, 32'(period_valid), v);
    chk({tag, ".locked"}, 32'(locked), l);
    chk({tag, ".fault"}, 32'(fault), f);
  endtask

  // One clk25 cycle on dut: inputs held across the edge, outputs read 1 later.
  task automatic step(input bit r, input bit c, input bit fc);
    rst = r; clken = c; fault_clr = fc;
    @(posedge clk25);
    #1;
  endtask

  task automatic step_t(input bit r, input bit c, input bit fc);
    rst_t = r; clken_t = c; clr_t = fc;
    @(posedge clk25);
    #1;
  endtask

  // Directed vectors: gap idle cycles, then one cycle with the given inputs.
  typedef struct {
    int gap;
    bit r;
    bit pulse;
    bit clr;
    int e_period;
    bit e_pv;
    bit e_locked;
    bit e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int gap, bit r, bit pulse, bit clr,
                              int p, bit v, bit l, bit f);
    vec_t x;
    x.gap = gap; x.r = r; x.pulse = pulse; x.clr = clr;
    x.e_period = p; x.e_pv = v; x.e_locked = l; x.e_fault = f;
    return x;
  endfunction

  // Reference model: remembers the timestamp of the reference pulse and
  // derives intervals and timeouts from elapsed time.
  typedef struct {
    int mode;      // 0 no reference, 1 searching, 2 locked
    int good;
    int ref_time;
    int period;
    bit pv;
    bit fault;
  } ms_t;

  function automatic ms_t mstep(ms_t s, int e, int tol, int l,
                                bit r, bit c, bit fc, int t);
    ms_t n;
    bit  ev;
    int  iv;
    n  = s;
    ev = 1'b0;
    n.pv = 1'b0;
    if (r) begin
      n.mode = 0; n.good = 0; n.period = 0; n.fault = 1'b0;
      return n;
    end
    if (c) begin
      if (s.mode == 0) begin
        n.mode = 1;
        n.good = 0;
      end else begin
        iv = t - s.ref_time;
        n.period = iv;
        n.pv = 1'b1;
        if (iv >= e - tol && iv <= e + tol) begin
          if (s.mode == 1) begin
            n.good = (s.good + 1 > l) ? l : s.good + 1;
            if (n.good == l) n.mode = 2;
          end
        end else begin
          n.good = 0;
          if (s.mode == 2) begin
            ev = 1'b1;
            n.mode = 1;
          end
        end
      end
      n.ref_time = t;
    end else if (s.mode != 0 && (t - s.ref_time) == e + tol) begin
      ev = (s.mode == 2);
      n.mode = 0;
      n.good = 0;
    end
    n.fault = ev ? 1'b1 : (fc ? 1'b0 : s.fault);
    return n;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ms_t m, mt;
    int  next_gap;
    int  sel;
    bit  r, c, fc;
    int  t;

    rst = 1'b1; clken = 1'b0; fault_clr = 1'b0;
    rst_t = 1'b1; clken_t = 1'b0; clr_t = 1'b0;

    // ---------------- reset state ----------------
    step(1, 0, 0);
    step(1, 1, 1);
    chk_all("reset", 0, 0, 0, 0);

    // ---------------- table-driven vectors ----------------
    vecs.push_back(mk( 9, 0, 1, 0,  0, 0, 0, 0)); // first pulse: reference only
    vecs.push_back(mk(24, 0, 1, 0, 25, 1, 0, 0));
    vecs.push_back(mk(24, 0, 1, 0, 25, 1, 0, 0));
    vecs.push_back(mk(24, 0, 1, 0, 25, 1, 0, 0));
    vecs.push_back(mk(24, 0, 1, 0, 25, 1, 1, 0)); // 5th pulse -> locked
    vecs.push_back(mk(11, 0, 1, 0, 12, 1, 0, 1)); // short interval while locked
    vecs.push_back(mk(24, 0, 1, 0, 25, 1, 0, 1));
    vecs.push_back(mk(24, 0, 1, 0, 25, 1, 0, 1));
    vecs.push_back(mk(24, 0, 1, 0, 25, 1, 0, 1));
    vecs.push_back(mk(24, 0, 1, 0, 25, 1, 1, 1)); // relock, fault sticky
    vecs.push_back(mk( 5, 0, 1, 1,  6, 1, 0, 1)); // clear races a fault: set wins
    vecs.push_back(mk( 0, 0, 0, 1,  6, 0, 0, 0)); // clear alone
    vecs.push_back(mk( 0, 1, 1, 0,  0, 0, 0, 0)); // reset beats clken
    vecs.push_back(mk( 4, 0, 1, 0,  0, 0, 0, 0)); // reference after reset
    vecs.push_back(mk( 0, 0, 1, 0,  1, 1, 0, 0)); // back-to-back pulses
    vecs.push_back(mk(24, 0, 1, 0, 25, 1, 0, 0));
    vecs.push_back(mk(24, 0, 1, 0, 25, 1, 0, 0));
    vecs.push_back(mk(24, 0, 1, 0, 25, 1, 0, 0));
    vecs.push_back(mk(24, 0, 1, 0, 25, 1, 1, 0));
    vecs.push_back(mk( 7, 1, 1, 0,  0, 0, 0, 0)); // reset mid-lock

    for (int i = 0; i < vecs.size(); i++) begin
      for (int g = 0; g < vecs[i].gap; g++) begin
        step(0, 0, 0);
        chk($sformatf("vec%0d.gap_pv", i), 32'(period_valid), 0);
      end
      step(vecs[i].r, vecs[i].pulse, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].e_period, vecs[i].e_pv,
              vecs[i].e_locked, vecs[i].e_fault);
    end

    // ---------------- missing pulse while locked ----------------
    step(0, 1, 0);
    for (int k = 0; k < LC; k++) begin
      repeat (24) step(0, 0, 0);
      step(0, 1, 0);
    end
    chk_all("miss.locked", 25, 1, 1, 0);
    for (int g = 1; g <= 24; g++) begin
      step(0, 0, 0);
      chk($sformatf("miss.hold%0d.locked", g), 32'(locked), 1);
      chk($sformatf("miss.hold%0d.pv", g), 32'(period_valid), 0);
    end
    step(0, 0, 0);
    chk_all("miss.timeout", 25, 0, 0, 1);
    repeat (5) begin
      step(0, 0, 0);
      chk("miss.after_pv", 32'(period_valid), 0);
    end
    step(0, 1, 0);
    chk_all("miss.ref_unmeasured", 25, 0, 0, 1);
    repeat (24) step(0, 0, 0);
    step(0, 1, 0);
    chk_all("miss.remeasure", 25, 1, 0, 1);

    // ---------------- tolerance +/-1 on dut_t ----------------
    step_t(1, 0, 0);
    step_t(0, 1, 0);
    begin
      int ivs[4];
      ivs = '{24, 26, 25, 24};
      for (int k = 0; k < 4; k++) begin
        repeat (ivs[k] - 1) step_t(0, 0, 0);
        step_t(0, 1, 0);
        chk($sformatf("tol.iv%0d.period", k), 32'(period_t), ivs[k]);
        chk($sformatf("tol.iv%0d.pv", k), 32'(period_valid_t), 1);
        chk($sformatf("tol.iv%0d.locked", k), 32'(locked_t), (k == 3) ? 1 : 0);
      end
    end
    repeat (25) step_t(0, 0, 0);
    chk("tol.slot26.locked", 32'(locked_t), 1);
    chk("tol.slot26.fault", 32'(fault_t), 0);
    step_t(0, 0, 0);
    chk("tol.timeout.locked", 32'(locked_t), 0);
    chk("tol.timeout.fault", 32'(fault_t), 1);
    chk("tol.timeout.pv", 32'(period_valid_t), 0);

    // ---------------- randomized, both instances vs model ----------------
    rst = 1'b1; rst_t = 1'b1; clken = 1'b0; clken_t = 1'b0;
    fault_clr = 1'b0; clr_t = 1'b0;
    @(posedge clk25); #1;
    m  = '{mode: 0, good: 0, ref_time: 0, period: 0, pv: 1'b0, fault: 1'b0};
    mt = m;
    next_gap = $urandom_range(0, 10);
    for (t = 0; t < 3000; t++) begin
      if (next_gap == 0) begin
        c = 1'b1;
        sel = $urandom_range(0, 99);
        if (sel < 60)      next_gap = EP - 1;
        else if (sel < 80) next_gap = $urandom_range(EP - 2, EP);
        else if (sel < 92) next_gap = $urandom_range(0, 30);
        else               next_gap = $urandom_range(27, 60);
      end else begin
        c = 1'b0;
        next_gap--;
      end
      fc = ($urandom_range(0, 15) == 0);
      r  = ($urandom_range(0, 599) == 0);
      rst = r; rst_t = r; clken = c; clken_t = c; fault_clr = fc; clr_t = fc;
      @(posedge clk25); #1;
      m  = mstep(m,  EP, 0, LC, r, c, fc, t);
      mt = mstep(mt, EP, 1, LC, r, c, fc, t);
      chk_all($sformatf("rnd%0d", t), m.period, m.pv, (m.mode == 2) ? 1 : 0, m.fault);
      chk($sformatf("rnd%0d.t.period", t), 32'(period_t), mt.period);
      chk($sformatf("rnd%0d.t.pv", t), 32'(period_valid_t), mt.pv);
      chk($sformatf("rnd%0d.t.locked", t), 32'(locked_t), (mt.mode == 2) ? 1 : 0);
      chk($sformatf("rnd%0d.t.fault", t), 32'(fault_t), mt.fault);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
